// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Bus-mapped transmit buffer. CPU bytes are queued in a
//                DEPTH-entry FIFO and drained one at a time to a UART sender
//                over the TX_DATA / TX_EN / TX_STATUS handshake. A status
//                register exposes fill level, busy and a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int          DEPTH        = 8,
    parameter int          AW           = 3,
    parameter logic [31:0] DATA_ADDR    = 32'h4000_0018,
    parameter logic [31:0] STAT_ADDR    = 32'h4000_0024,
    parameter int          BUSY_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  TX_DATA,
    output logic        TX_EN,
    input  logic        TX_STATUS
);

    localparam int c_tw = $clog2(BUSY_TIMEOUT + 1);
    localparam int c_cw = AW + 1;

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_wait_busy = 2'd1;
    localparam logic [1:0] c_st_wait_done = 2'd2;

    localparam logic [AW-1:0]   c_ptr_one      = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]     c_cnt_one      = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]     c_cnt_full     = c_cw'(DEPTH);
    localparam logic [c_tw-1:0] c_tmr_one      = {{(c_tw-1){1'b0}}, 1'b1};
    localparam logic [c_tw-1:0] c_timeout_last = c_tw'(BUSY_TIMEOUT - 1);

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_overflow;
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_tw-1:0] r_timer;
    logic [c_tw-1:0] w_timer_nxt;
    logic [7:0]      r_tx_data;
    logic            r_tx_en;

    logic            w_empty;
    logic            w_full;
    logic            w_push_req;
    logic            w_push;
    logic            w_pop;
    logic            w_ovf_set;
    logic            w_ovf_clr;
    logic            w_busy;
    logic [3:0]      w_count4;
    logic            w_unused_wdata;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_cnt_full);
    assign w_busy     = (r_state != c_st_idle);
    assign w_count4   = 4'(r_count);
    assign w_push_req = MemWr && (Addr == DATA_ADDR);
    // A full FIFO still accepts a byte when the drain pops in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && w_full && !w_pop;
    assign w_ovf_clr  = MemWr && (Addr == STAT_ADDR) && WriteData[2];

    assign w_unused_wdata = ^WriteData[31:8];

    // FIFO storage write port; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= WriteData[7:0];
        end
    end

    // Pointers, fill count and sticky overflow (set beats clear).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_one;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Drain FSM state, busy timer and registered sender outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_timer   <= '0;
            r_tx_en   <= 1'b0;
            r_tx_data <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_tx_en <= w_pop;
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
        end
    end

    // Drain FSM next-state: launch, wait for sender to go busy (or time out), wait for idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (!w_empty && TX_STATUS) begin
                    w_state_nxt = c_st_wait_busy;
                end
            end
            c_st_wait_busy: begin
                if (!TX_STATUS) begin
                    w_state_nxt = c_st_wait_done;
                end else if (r_timer == c_timeout_last) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_wait_done: begin
                if (TX_STATUS) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Drain FSM outputs: pop/launch strobe and the busy-wait timer.
    always_comb begin
        w_pop       = 1'b0;
        w_timer_nxt = '0;
        case (r_state)
            c_st_idle: begin
                w_pop = !w_empty && TX_STATUS;
            end
            c_st_wait_busy: begin
                if (TX_STATUS) begin
                    w_timer_nxt = r_timer + c_tmr_one;
                end
            end
            default: begin
                w_pop       = 1'b0;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Status register read mux; every other address reads as zero.
    always_comb begin
        ReadData = '0;
        if (MemRd && (Addr == STAT_ADDR)) begin
            ReadData[0]    = w_empty;
            ReadData[1]    = w_full;
            ReadData[2]    = r_overflow;
            ReadData[3]    = w_busy;
            ReadData[11:8] = w_count4;
        end
    end

    assign TX_DATA = r_tx_data;
    assign TX_EN   = r_tx_en;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Directed self-checking bench for uart_tx_fifo with a simple
//                UART sender model and a launch monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam logic [31:0] DATA_ADDR = 32'h4000_0018;
    localparam logic [31:0] STAT_ADDR = 32'h4000_0024;
    localparam int          SEND_LEN  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRd;
    logic        MemWr;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  TX_DATA;
    logic        TX_EN;
    logic        TX_STATUS = 1'b1;

    int vectors = 0;
    int errors  = 0;

    // Sender model controls
    logic sender_auto  = 1'b0;
    logic sender_level = 1'b1;
    int   busy_left    = 0;

    // Monitor state
    logic [7:0] launch_q [$];
    int         launch_cyc [$];
    int         cyc     = 0;
    logic       prev_en = 1'b0;
    logic       b2b_seen = 1'b0;

    uart_tx_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .MemRd     (MemRd),
        .MemWr     (MemWr),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .TX_DATA   (TX_DATA),
        .TX_EN     (TX_EN),
        .TX_STATUS (TX_STATUS)
    );

    always #5 clk = ~clk;

    // Sender model: manual level, or busy for SEND_LEN cycles after each launch.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!sender_auto) begin
                TX_STATUS = sender_level;
            end else if (busy_left > 0) begin
                busy_left = busy_left - 1;
                if (busy_left == 0) TX_STATUS = 1'b1;
            end else if (TX_EN) begin
                busy_left = SEND_LEN;
                TX_STATUS = 1'b0;
            end else begin
                TX_STATUS = 1'b1;
            end
        end
    end

    // Launch monitor: records launched bytes and cycle numbers.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            cyc = cyc + 1;
            if (TX_EN) begin
                if (prev_en) b2b_seen = 1'b1;
                launch_q.push_back(TX_DATA);
                launch_cyc.push_back(cyc);
            end
            prev_en = TX_EN;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        tick();
        MemWr = 1'b1; Addr = a; WriteData = d;
        tick();
        MemWr = 1'b0; Addr = '0; WriteData = '0;
    endtask

    task automatic read_status(output logic [31:0] v);
        MemRd = 1'b1; Addr = STAT_ADDR;
        #1;
        v = ReadData;
        MemRd = 1'b0; Addr = '0;
    endtask

    task automatic wait_launches(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (launch_q.size() >= n) break;
            tick();
        end
    endtask

    task automatic test_reset();
        logic [31:0] st;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        read_status(st);
        vectors++; if (st !== 32'h0000_0001) begin errors++; $display("FAIL reset_status got=%h exp=%h", st, 32'h1); end
        vectors++; if (TX_EN !== 1'b0) begin errors++; $display("FAIL reset_tx_en got=%b exp=0", TX_EN); end
        vectors++; if (TX_DATA !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", TX_DATA); end
        MemRd = 1'b1; Addr = DATA_ADDR; #1;
        vectors++; if (ReadData !== 32'h0) begin errors++; $display("FAIL read_other_addr got=%h exp=0", ReadData); end
        MemRd = 1'b0; Addr = STAT_ADDR; #1;
        vectors++; if (ReadData !== 32'h0) begin errors++; $display("FAIL read_no_strobe got=%h exp=0", ReadData); end
        Addr = '0;
        launch_q.delete();
        repeat (20) tick();
        vectors++; if (launch_q.size() !== 0) begin errors++; $display("FAIL idle_no_launch got=%0d exp=0", launch_q.size()); end
    endtask

    task automatic test_single_byte();
        logic [31:0] st;
        sender_auto = 1'b1;
        tick();
        bus_write(DATA_ADDR, 32'h0000_005A);
        vectors++; if (TX_EN !== 1'b0) begin errors++; $display("FAIL single_early_en got=%b exp=0", TX_EN); end
        tick();
        vectors++; if (TX_EN !== 1'b1) begin errors++; $display("FAIL single_en got=%b exp=1", TX_EN); end
        vectors++; if (TX_DATA !== 8'h5A) begin errors++; $display("FAIL single_data got=%h exp=5a", TX_DATA); end
        tick();
        vectors++; if (TX_EN !== 1'b0) begin errors++; $display("FAIL single_en_pulse got=%b exp=0", TX_EN); end
        repeat (3) tick();
        read_status(st);
        vectors++; if (st !== 32'h0000_0009) begin errors++; $display("FAIL single_busy_status got=%h exp=%h", st, 32'h9); end
        repeat (12) tick();
        read_status(st);
        vectors++; if (st !== 32'h0000_0001) begin errors++; $display("FAIL single_idle_status got=%h exp=%h", st, 32'h1); end
    endtask

    task automatic test_fill_order();
        logic [31:0] st;
        sender_auto = 1'b0; sender_level = 1'b0;
        tick(); tick();
        for (int i = 1; i <= 8; i++) bus_write(DATA_ADDR, 32'(i));
        read_status(st);
        vectors++; if (st !== 32'h0000_0802) begin errors++; $display("FAIL fill_full got=%h exp=%h", st, 32'h802); end
        bus_write(DATA_ADDR, 32'h0000_00FF);
        read_status(st);
        vectors++; if (st !== 32'h0000_0806) begin errors++; $display("FAIL fill_overflow got=%h exp=%h", st, 32'h806); end
        launch_q.delete();
        tick();
        sender_auto = 1'b1;
        wait_launches(8, 400);
        repeat (20) tick();
        vectors++; if (launch_q.size() !== 8) begin errors++; $display("FAIL fill_launch_count got=%0d exp=8", launch_q.size()); end
        for (int i = 0; i < 8 && i < launch_q.size(); i++) begin
            vectors++;
            if (launch_q[i] !== 8'(i + 1)) begin errors++; $display("FAIL fill_order[%0d] got=%h exp=%h", i, launch_q[i], 8'(i + 1)); end
        end
        read_status(st);
        vectors++; if (st !== 32'h0000_0005) begin errors++; $display("FAIL fill_drained got=%h exp=%h", st, 32'h5); end
    endtask

    task automatic test_overflow_clear();
        logic [31:0] st;
        bus_write(STAT_ADDR, 32'hFFFF_FFFB);
        read_status(st);
        vectors++; if (st !== 32'h0000_0005) begin errors++; $display("FAIL ovf_keep got=%h exp=%h", st, 32'h5); end
        bus_write(STAT_ADDR, 32'h0000_0004);
        read_status(st);
        vectors++; if (st !== 32'h0000_0001) begin errors++; $display("FAIL ovf_clear got=%h exp=%h", st, 32'h1); end
        sender_auto = 1'b0; sender_level = 1'b0;
        tick(); tick();
        for (int i = 0; i < 8; i++) bus_write(DATA_ADDR, 32'(8'h11 + i));
        bus_write(DATA_ADDR, 32'h0000_00FF);
        read_status(st);
        vectors++; if (st !== 32'h0000_0806) begin errors++; $display("FAIL ovf_set_again got=%h exp=%h", st, 32'h806); end
        bus_write(STAT_ADDR, 32'h0000_0004);
        read_status(st);
        vectors++; if (st !== 32'h0000_0802) begin errors++; $display("FAIL ovf_clear_full got=%h exp=%h", st, 32'h802); end
    endtask

    task automatic test_full_pop();
        logic [31:0] st;
        logic [7:0]  exp_b;
        launch_q.delete();
        tick();
        sender_level = 1'b1;
        MemWr = 1'b1; Addr = DATA_ADDR; WriteData = 32'h0000_00AA;
        tick();
        MemWr = 1'b0; Addr = '0; WriteData = '0;
        sender_auto = 1'b1;
        vectors++; if (TX_EN !== 1'b1 || TX_DATA !== 8'h11) begin errors++; $display("FAIL fullpop_launch got=%b/%h exp=1/11", TX_EN, TX_DATA); end
        read_status(st);
        vectors++; if (st !== 32'h0000_080A) begin errors++; $display("FAIL fullpop_status got=%h exp=%h", st, 32'h80A); end
        wait_launches(9, 400);
        repeat (20) tick();
        vectors++; if (launch_q.size() !== 9) begin errors++; $display("FAIL fullpop_count got=%0d exp=9", launch_q.size()); end
        for (int i = 0; i < 9 && i < launch_q.size(); i++) begin
            exp_b = (i == 8) ? 8'hAA : 8'(8'h11 + i);
            vectors++;
            if (launch_q[i] !== exp_b) begin errors++; $display("FAIL fullpop_order[%0d] got=%h exp=%h", i, launch_q[i], exp_b); end
        end
        read_status(st);
        vectors++; if (st !== 32'h0000_0001) begin errors++; $display("FAIL fullpop_drained got=%h exp=%h", st, 32'h1); end
    endtask

    task automatic test_timeout();
        logic [31:0] st;
        int          gap;
        sender_auto = 1'b0; sender_level = 1'b1;
        tick();
        launch_q.delete(); launch_cyc.delete();
        bus_write(DATA_ADDR, 32'h0000_00C1);
        bus_write(DATA_ADDR, 32'h0000_00C2);
        wait_launches(2, 100);
        vectors++; if (launch_q.size() !== 2) begin errors++; $display("FAIL timeout_count got=%0d exp=2", launch_q.size()); end
        if (launch_q.size() >= 2) begin
            vectors++; if (launch_q[0] !== 8'hC1 || launch_q[1] !== 8'hC2) begin errors++; $display("FAIL timeout_bytes got=%h,%h exp=c1,c2", launch_q[0], launch_q[1]); end
            gap = launch_cyc[1] - launch_cyc[0];
            vectors++; if (gap !== 17) begin errors++; $display("FAIL timeout_gap got=%0d exp=17", gap); end
        end
        repeat (25) tick();
        read_status(st);
        vectors++; if (st !== 32'h0000_0001) begin errors++; $display("FAIL timeout_empty got=%h exp=%h", st, 32'h1); end
        vectors++; if (TX_DATA !== 8'hC2 || TX_EN !== 1'b0) begin errors++; $display("FAIL timeout_hold got=%h/%b exp=c2/0", TX_DATA, TX_EN); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] st;
        sender_level = 1'b0;
        tick(); tick();
        for (int i = 0; i < 3; i++) bus_write(DATA_ADDR, 32'(8'h30 + i));
        read_status(st);
        vectors++; if (st !== 32'h0000_0300) begin errors++; $display("FAIL rstmid_count got=%h exp=%h", st, 32'h300); end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sender_level = 1'b1;
        launch_q.delete();
        repeat (20) tick();
        vectors++; if (launch_q.size() !== 0) begin errors++; $display("FAIL rstmid_launch got=%0d exp=0", launch_q.size()); end
        read_status(st);
        vectors++; if (st !== 32'h0000_0001) begin errors++; $display("FAIL rstmid_status got=%h exp=%h", st, 32'h1); end
    endtask

    task automatic test_back_to_back();
        vectors++; if (b2b_seen !== 1'b0) begin errors++; $display("FAIL tx_en_back_to_back got=%b exp=0", b2b_seen); end
    endtask

    initial begin
        reset = 1'b1; MemRd = 1'b0; MemWr = 1'b0; Addr = '0; WriteData = '0;
        test_reset();
        test_single_byte();
        test_fill_order();
        test_overflow_clear();
        test_full_pop();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
